alu_execute: RTL and testbench
==============================

Name: alu_execute

Overview:
- Execute/writeback stage directly downstream of the register file.
- Consumes the two read ports plus opcode and destination index, and computes the result.
- Drives the register file write port: write_enable, write_destination, write_data.
- Single-cycle ALU ops, plus iterative multiply/divide with a busy/done handshake back to the control sequencer.

Parameters:
- W, 16, datapath width; must match the register file width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; operands/opcode/dest sampled on the same edge.
- opcode  input  6  operation code.
- operand_a  input  W  register_data_1 (for MOV/IMOV this carries the source index/immediate).
- operand_b  input  W  register_data_2.
- dest  input  2  destination register index (0=X, 1=Y, 2=ACCUMULATOR).
- busy  output  1  high from accepted start until the writeback cycle inclusive.
- done  output  1  one-cycle pulse, coincident with the writeback cycle.
- write_enable  output  1  register file write strobe.
- write_destination  output  2  register file write index.
- write_data  output  W  register file write data.
- flag_z  output  1  result zero.
- flag_n  output  1  result MSB.
- flag_c  output  1  carry/borrow out.
- flag_v  output  1  signed overflow.
- illegal  output  1  one-cycle pulse on unknown opcode or dest==3.

Behaviour:
- Reset: all outputs, flags, FSM (IDLE) and internal registers go to 0 immediately on rst low.
- Opcodes:
  - ADD 000001, SUB 000010: C = carry out (SUB: C=1 means borrow).
  - MOV 000100 and IMOV 100100: result = operand_a.
  - AND 000101, OR 000110, XOR 000111.
  - LSL 001000, LSR 001001: shift amount = operand_b[3:0]; C = last bit shifted out, 0 if the amount is 0.
  - MUL 001010: low W bits of the unsigned product; C = 1 if the high half is nonzero.
  - DIV 001011: unsigned quotient.
- FSM states: IDLE, EXEC, ITER, WB.
- IDLE: start=1 latches the inputs.
  - Single-cycle op -> EXEC.
  - MUL/DIV -> ITER with counter = W.
  - Illegal opcode or dest==3 -> pulse illegal next cycle, no write, stay IDLE.
- EXEC: compute into the result register -> WB.
- ITER: one shift-add (MUL) or restoring-subtract (DIV) step per cycle; counter decrements; at 0 -> WB.
- WB: write_enable=1, done=1, write_destination=latched dest, write_data=result, flags updated; -> IDLE.
- Latency: start accepted at edge N.
  - Single-cycle ops: write_enable high during cycle N+2.
  - MUL/DIV: write_enable high during cycle N+2+W.
- start while busy=1 is ignored (no queueing); the requester must hold off until done.
- Flags hold their value between writebacks.
  - V is defined for ADD/SUB only; all other ops clear it.
- Divide by zero: quotient = all ones, C=1, no hang; still W iterations.
- Reset mid-ITER: operation abandoned, no write ever issued.
- write_enable never asserts outside WB, and never for an illegal op.

Optional Feature:
- Macro ALU_MULDIV_EN.
- Defined: MUL/DIV are implemented as above.
- Undefined: MUL/DIV decode as illegal, the ITER state and the iterative datapath are not instantiated, and busy is never high for more than 2 cycles.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (including MOV/IMOV, matching the register file).
  - register index constants X=0, Y=1, ACCUMULATOR=2.
  - FSM state encoding.
  - width constant default 16.
- One sub-module, seq_muldiv: the iterative unsigned multiply/restoring divide.
  - Ports: start, op select, a, b, result, carry, done.
  - Instantiated only under ALU_MULDIV_EN.

Test Plan:
- ADD a=0x7FFF b=0x0001 dest=2 -> write at N+2, write_data=0x8000, dest=2, N=1, V=1, C=0, Z=0, done pulse 1 cycle.
- SUB a=0x0003 b=0x0005 dest=0 -> write_data=0xFFFE, C=1, N=1; then MOV a=0x0002 dest=1 -> write_data=0x0002, V=0.
- MUL a=0x0005 b=0x0003 -> busy for W+2 cycles, write_data=0x000F, C=0; MUL 0x0100*0x0100 -> 0x0000, Z=1, C=1; start pulses while busy produce no extra writes.
- DIV a=0x0064 b=0x0007 -> write_data=0x000E; DIV by 0 -> 0xFFFF, C=1, completes in W+2 cycles.
- opcode 111111, and ADD with dest=3 -> illegal pulse, no write_enable, flags unchanged.
- rst low during the 5th ITER cycle -> all outputs 0 asynchronously; after release no write occurs, and a new ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute/writeback stage.
// Contents: opcode codes (matching the register file encoding, including
// MOV/IMOV), register index constants, the FSM state encoding, the default
// datapath width and opcode classification helpers.
// Optional feature macro used by the users of this package: ALU_MULDIV_EN.
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int WIDTH = 16;

  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_MOV  = 6'b000100;
  localparam logic [5:0] OP_IMOV = 6'b100100;
  localparam logic [5:0] OP_AND  = 6'b000101;
  localparam logic [5:0] OP_OR   = 6'b000110;
  localparam logic [5:0] OP_XOR  = 6'b000111;
  localparam logic [5:0] OP_LSL  = 6'b001000;
  localparam logic [5:0] OP_LSR  = 6'b001001;
  localparam logic [5:0] OP_MUL  = 6'b001010;
  localparam logic [5:0] OP_DIV  = 6'b001011;

  localparam logic [1:0] REG_X           = 2'd0;
  localparam logic [1:0] REG_Y           = 2'd1;
  localparam logic [1:0] REG_ACCUMULATOR = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ITER = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Operations finished by the combinational ALU in one EXEC cycle.
  function automatic logic is_single_op(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MOV, OP_IMOV, OP_AND, OP_OR, OP_XOR, OP_LSL, OP_LSR:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

  // Operations that need the iterative multiply/divide unit.
  function automatic logic is_muldiv_op(input logic [5:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_execute_if.sv
// ---------------------------------------------------------------------------
// alu_execute_if
// Bundles the request side (control sequencer + register file read ports)
// and the writeback side (register file write port, flags, handshake) of the
// execute stage.
//   master : sequencer/testbench view (drives start/opcode/operands/dest)
//   slave  : execute stage view (drives busy/done/write port/flags/illegal)
// ---------------------------------------------------------------------------
interface alu_execute_if import alu_pkg::*; #(parameter int W = WIDTH);

  logic         start;
  logic [5:0]   opcode;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic [1:0]   dest;

  logic         busy;
  logic         done;
  logic         write_enable;
  logic [1:0]   write_destination;
  logic [W-1:0] write_data;
  logic         flag_z;
  logic         flag_n;
  logic         flag_c;
  logic         flag_v;
  logic         illegal;

  modport master (
    output start, opcode, operand_a, operand_b, dest,
    input  busy, done, write_enable, write_destination, write_data,
    input  flag_z, flag_n, flag_c, flag_v, illegal
  );

  modport slave (
    input  start, opcode, operand_a, operand_b, dest,
    output busy, done, write_enable, write_destination, write_data,
    output flag_z, flag_n, flag_c, flag_v, illegal
  );

endinterface

// File: rtl/seq_muldiv.sv
// ---------------------------------------------------------------------------
// seq_muldiv
// Iterative unsigned multiply (shift-add) and restoring divide, one step per
// clock, W steps per operation.
// Ports:
//   clk, rst   clock / asynchronous active-low reset
//   start_i    load operands and begin (a_i, b_i, op_div_i sampled)
//   op_div_i   0 = multiply, 1 = divide
//   a_i, b_i   multiplicand/multiplier or dividend/divisor
//   result_o   low product half or quotient
//   carry_o    multiply: high product half nonzero; divide: divisor was zero
//   done_o     high for the one cycle in which result_o/carry_o are final
// ---------------------------------------------------------------------------
module seq_muldiv import alu_pkg::*; #(parameter int W = WIDTH) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         op_div_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] result_o,
  output logic         carry_o,
  output logic         done_o
);

  localparam int CW = $clog2(W + 1);

  // hi: partial product high half / partial remainder
  // lo: multiplier shifting out, product low half / dividend shifting out, quotient
  logic [W-1:0]  hi_q, hi_d, lo_q, lo_d, b_q;
  logic          div_q, active_q, active_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    add_sum;
  logic [W:0]    shifted;
  logic          fits;
  logic [W-1:0]  rem_sub;

  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    add_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shifted  = {hi_q, lo_q[W-1]};
    fits     = shifted >= {1'b0, b_q};
    // When the divisor fits, the true difference is below 2^W, so the
    // truncated subtraction is exact.
    rem_sub  = shifted[W-1:0] - b_q;
    if (start_i) begin
      hi_d     = '0;
      lo_d     = a_i;
      cnt_d    = CW'(W);
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q != 0) begin
        cnt_d = cnt_q - 1'b1;
        if (div_q) begin
          // A zero divisor always "fits", so the quotient saturates to all ones.
          hi_d = fits ? rem_sub : shifted[W-1:0];
          lo_d = {lo_q[W-2:0], fits};
        end else begin
          hi_d = add_sum[W:1];
          lo_d = {add_sum[0], lo_q[W-1:1]};
        end
      end else begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      div_q    <= 1'b0;
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      if (start_i) begin
        b_q   <= b_i;
        div_q <= op_div_i;
      end
    end
  end

  assign result_o = lo_q;
  assign carry_o  = div_q ? (b_q == '0) : (hi_q != '0);
  assign done_o   = active_q && (cnt_q == '0);

endmodule

// File: rtl/alu_execute.sv
// ---------------------------------------------------------------------------
// alu_execute
// Execute/writeback stage behind the register file. Accepts one request on
// start, computes it (single-cycle ALU or iterative MUL/DIV) and issues one
// register file write with done, updating the Z/N/C/V flags.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   bus   alu_execute_if.slave: start/opcode/operand_a/operand_b/dest in,
//         busy/done/write_enable/write_destination/write_data,
//         flag_z/flag_n/flag_c/flag_v/illegal out
// Optional feature: ALU_MULDIV_EN enables MUL/DIV (seq_muldiv); without it
// MUL/DIV decode as illegal and no iterative datapath is built.
// ---------------------------------------------------------------------------
module alu_execute import alu_pkg::*; #(parameter int W = WIDTH) (
  input logic         clk,
  input logic         rst,
  alu_execute_if.slave bus
);

  state_t       state_q, state_d;
  logic [W-1:0] a_q, b_q, result_q;
  logic [5:0]   op_q;
  logic [1:0]   dest_q;
  logic         z_q, n_q, c_q, v_q, illegal_q;

  logic accept, op_ok, muldiv_req;

  // Requests are only looked at in IDLE; anything while busy is dropped.
  assign accept = (state_q == ST_IDLE) && bus.start;

`ifdef ALU_MULDIV_EN
  logic [W-1:0] md_result;
  logic         md_carry, md_done;

  assign muldiv_req = is_muldiv_op(bus.opcode);

  seq_muldiv #(.W(W)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start_i  (accept && op_ok && muldiv_req),
    .op_div_i (bus.opcode == OP_DIV),
    .a_i      (bus.operand_a),
    .b_i      (bus.operand_b),
    .result_o (md_result),
    .carry_o  (md_carry),
    .done_o   (md_done)
  );
`else
  assign muldiv_req = 1'b0;
`endif

  assign op_ok = (is_single_op(bus.opcode) || muldiv_req) && (bus.dest <= REG_ACCUMULATOR);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && op_ok) state_d = muldiv_req ? ST_ITER : ST_EXEC;
      ST_EXEC: state_d = ST_WB;
`ifdef ALU_MULDIV_EN
      ST_ITER: if (md_done) state_d = ST_WB;
`endif
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Single-cycle ALU on the latched operands.
  logic [W-1:0] alu_res;
  logic         alu_c, alu_v;
  logic [W:0]   wide;
  logic [3:0]   amt;

  always_comb begin
    alu_res = a_q;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    wide    = '0;
    amt     = b_q[3:0];
    case (op_q)
      OP_ADD: begin
        wide    = {1'b0, a_q} + {1'b0, b_q};
        alu_res = wide[W-1:0];
        alu_c   = wide[W];
        alu_v   = (a_q[W-1] == b_q[W-1]) && (alu_res[W-1] != a_q[W-1]);
      end
      OP_SUB: begin
        wide    = {1'b0, a_q} - {1'b0, b_q};
        alu_res = wide[W-1:0];
        alu_c   = wide[W];
        alu_v   = (a_q[W-1] != b_q[W-1]) && (alu_res[W-1] != a_q[W-1]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      // The extra bit catches the last bit shifted out; zero for amount 0.
      OP_LSL: begin
        wide    = {1'b0, a_q} << amt;
        alu_res = wide[W-1:0];
        alu_c   = wide[W];
      end
      OP_LSR: begin
        wide    = {a_q, 1'b0} >> amt;
        alu_res = wide[W:1];
        alu_c   = wide[0];
      end
      default: alu_res = a_q;  // MOV / IMOV
    endcase
  end

  // Result and flags load on the edge entering WB so they are valid with
  // write_enable and then hold until the next writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      dest_q    <= '0;
      result_q  <= '0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      c_q       <= 1'b0;
      v_q       <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= accept && !op_ok;
      if (accept && op_ok) begin
        a_q    <= bus.operand_a;
        b_q    <= bus.operand_b;
        op_q   <= bus.opcode;
        dest_q <= bus.dest;
      end
      if (state_q == ST_EXEC) begin
        result_q <= alu_res;
        z_q      <= (alu_res == '0);
        n_q      <= alu_res[W-1];
        c_q      <= alu_c;
        v_q      <= alu_v;
      end
`ifdef ALU_MULDIV_EN
      if ((state_q == ST_ITER) && md_done) begin
        result_q <= md_result;
        z_q      <= (md_result == '0);
        n_q      <= md_result[W-1];
        c_q      <= md_carry;
        v_q      <= 1'b0;
      end
`endif
    end
  end

  assign bus.busy              = (state_q != ST_IDLE);
  assign bus.done              = (state_q == ST_WB);
  assign bus.write_enable      = (state_q == ST_WB);
  assign bus.write_destination = dest_q;
  assign bus.write_data        = result_q;
  assign bus.flag_z            = z_q;
  assign bus.flag_n            = n_q;
  assign bus.flag_c            = c_q;
  assign bus.flag_v            = v_q;
  assign bus.illegal           = illegal_q;

endmodule

// File: tb/tb_alu_execute.sv
// ---------------------------------------------------------------------------
// tb_alu_execute
// Directed and randomized requests against an arithmetic reference model;
// covers latency, writeback values, flags, illegal requests, requests while
// busy and asynchronous reset in the middle of an operation.
// Adapts to ALU_MULDIV_EN: without it MUL/DIV are expected to be illegal.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_execute;
  import alu_pkg::*;

  localparam int W    = 16;
  localparam int MASK = 32'h0000_FFFF;
`ifdef ALU_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_execute_if #(.W(W)) bus();

  alu_execute #(.W(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int exp_wr = 0;
  bit ez = 0, en = 0, ec = 0, ev = 0;  // model flags

  always @(negedge clk) if (bus.write_enable === 1'b1) wr_count++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic void model(input logic [5:0] op, input int a, input int b,
                                output bit legal, output bit md, output int res,
                                output bit c, output bit v);
    int sa, sb, amt;
    longint p;
    legal = 1; md = 0; res = 0; c = 0; v = 0;
    sa  = (a >= 32768) ? a - 65536 : a;
    sb  = (b >= 32768) ? b - 65536 : b;
    amt = b & 15;
    case (op)
      OP_ADD: begin
        res = (a + b) & MASK;
        c   = (a + b) > MASK;
        v   = (sa + sb > 32767) || (sa + sb < -32768);
      end
      OP_SUB: begin
        res = (a - b) & MASK;
        c   = a < b;
        v   = (sa - sb > 32767) || (sa - sb < -32768);
      end
      OP_MOV, OP_IMOV: res = a;
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_LSL: begin
        res = (a << amt) & MASK;
        c   = (amt != 0) && (((a >> (16 - amt)) & 1) == 1);
      end
      OP_LSR: begin
        res = a >> amt;
        c   = (amt != 0) && (((a >> (amt - 1)) & 1) == 1);
      end
      OP_MUL: begin
        md = 1; legal = MD_EN;
        p   = longint'(a) * longint'(b);
        res = int'(p & MASK);
        c   = (p >> 16) != 0;
      end
      OP_DIV: begin
        md = 1; legal = MD_EN;
        if (b == 0) begin res = MASK; c = 1; end
        else        res = a / b;
      end
      default: legal = 0;
    endcase
  endfunction

  task automatic run_op(input logic [5:0] op, input int a, input int b,
                        input logic [1:0] dst, input bit noise);
    bit lg, md, c, v, seen, busy_drop;
    int res, lat, k;
    model(op, a, b, lg, md, res, c, v);
    if (dst == 2'd3) lg = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = op; bus.dest = dst;
    bus.operand_a = 16'(a); bus.operand_b = 16'(b);
    @(negedge clk);  // cycle N+1
    bus.start = 1'b0;
    bus.opcode = 6'($urandom); bus.operand_a = 16'($urandom); bus.operand_b = 16'($urandom);
    bus.dest = 2'($urandom);
    if (!lg) begin
      $display("op=%b a=%04h b=%04h dest=%0d -> illegal=%0d", op, a, b, dst, bus.illegal);
      check_eq("illegal_pulse", bus.illegal, 1);
      check_eq("illegal_no_we", bus.write_enable, 0);
      check_eq("illegal_busy", bus.busy, 0);
      @(negedge clk);
      check_eq("illegal_one_cycle", bus.illegal, 0);
      check_eq("illegal_flags_hold", {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, {ez, en, ec, ev});
      return;
    end
    lat = md ? W + 2 : 2;
    k = 1; seen = 0; busy_drop = 0;
    while (k <= lat + 4) begin
      bus.start = 1'b0;
      if (bus.write_enable === 1'b1) begin seen = 1; break; end
      if (bus.busy !== 1'b1) busy_drop = 1;
      if (noise && (k % 2 == 1) && (k <= lat - 2)) begin
        bus.start = 1'b1; bus.opcode = OP_ADD; bus.dest = 2'($urandom_range(0, 2));
      end
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    check_eq("wb_seen", seen, 1);
    if (!seen) return;
    ez = (res == 0); en = ((res >> 15) & 1) == 1; ec = c; ev = v;
    exp_wr++;
    $display("op=%b a=%04h b=%04h dest=%0d -> data=%04h lat=%0d zncv=%b%b%b%b",
             op, a, b, dst, bus.write_data, k, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v);
    check_eq("latency", k, lat);
    check_eq("busy_until_wb", busy_drop, 0);
    check_eq("wb_busy_done", {bus.busy, bus.done}, 2'b11);
    check_eq("write_data", bus.write_data, res);
    check_eq("write_dest", bus.write_destination, dst);
    check_eq("flags_zncv", {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, {ez, en, ec, ev});
    @(negedge clk);
    check_eq("after_wb_we_done_busy", {bus.write_enable, bus.done, bus.busy}, 3'b000);
  endtask

  function automatic logic [25:0] all_outputs();
    return {bus.busy, bus.done, bus.write_enable, bus.write_destination, bus.write_data,
            bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.illegal};
  endfunction

  logic [5:0] op_table [11] = '{OP_ADD, OP_SUB, OP_MOV, OP_IMOV, OP_AND, OP_OR,
                                OP_XOR, OP_LSL, OP_LSR, OP_MUL, OP_DIV};

  initial begin
    int wr_before, sel;
    logic [5:0] rop;
    logic [1:0] rdst;
    bus.start = 1'b0; bus.opcode = '0; bus.operand_a = '0; bus.operand_b = '0; bus.dest = '0;
    #2;
    check_eq("reset_outputs", all_outputs(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Directed cases
    run_op(OP_ADD, 32'h7FFF, 32'h0001, 2'd2, 0);
    run_op(OP_SUB, 32'h0003, 32'h0005, 2'd0, 0);
    run_op(OP_MOV, 32'h0002, 32'h1234, 2'd1, 0);
    run_op(OP_MUL, 32'h0005, 32'h0003, 2'd2, 1);
    run_op(OP_MUL, 32'h0100, 32'h0100, 2'd0, 1);
    run_op(OP_DIV, 32'h0064, 32'h0007, 2'd1, 1);
    run_op(OP_DIV, 32'h1234, 32'h0000, 2'd2, 0);
    run_op(OP_LSL, 32'h8001, 32'h0001, 2'd0, 0);
    run_op(OP_LSR, 32'h0003, 32'h0010, 2'd1, 0);  // amount 0
    run_op(6'b111111, 32'h0001, 32'h0001, 2'd0, 0);
    run_op(OP_ADD, 32'h0001, 32'h0001, 2'd3, 0);

    // Reset in the middle of an operation (5th ITER cycle when MUL/DIV exist)
    wr_before = wr_count;
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = MD_EN ? OP_MUL : OP_ADD;
    bus.operand_a = 16'h1111; bus.operand_b = 16'h0003; bus.dest = 2'd1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (MD_EN ? 4 : 0) @(negedge clk);
    #1 rst = 1'b0;
    #1 check_eq("async_reset_outputs", all_outputs(), 0);
    ez = 0; en = 0; ec = 0; ev = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (W + 6) @(negedge clk);
    check_eq("no_write_after_reset", wr_count, wr_before);
    run_op(OP_ADD, 32'h1234, 32'h4321, 2'd2, 0);

    // Randomized requests
    for (int i = 0; i < 40; i++) begin
      sel  = $urandom_range(0, 12);
      rop  = (sel < 11) ? op_table[sel] : ((sel == 11) ? 6'b111111 : 6'($urandom));
      rdst = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      run_op(rop, int'($urandom & MASK), int'($urandom & MASK), rdst, $urandom_range(0, 1) == 1);
    end

    repeat (3) @(negedge clk);
    check_eq("write_count", wr_count, exp_wr);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "time limit");
  end

endmodule
